mux_n_pipe: RTL and testbench

- Parametrised N-input selector with a registered output and a configurable pipeline depth.
- Serves the MIPS datapath wherever a selected field must be carried across pipeline stages, e.g. the destination-register number (rt/rd/$31) travelling from ID to WB.
- Adds stall, flush, valid tracking and illegal-select detection so a stage can use it directly as its pipeline register.

---
 rtl/mux_n_pipe_if.sv | 26 ++
 rtl/mux_n_pipe.sv | 76 +++++++
 tb/tb_mux_n_pipe.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mux_n_pipe_if.sv
// Bundle of the selector's data, select, control and result signals.
// The master side drives the operation; the slave side is the pipelined selector.
interface mux_n_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] din;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic                    sel_err;

  modport master (
    output din, sel, in_valid, stall, flush,
    input  out, out_valid, sel_err
  );

  modport slave (
    input  din, sel, in_valid, stall, flush,
    output out, out_valid, sel_err
  );
endinterface

// File: rtl/mux_n_pipe.sv
// N-input selector with a STAGES-deep registered pipeline.
// The pipeline carries valid and illegal-select flags alongside the data.
module mux_n_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1
) (
  input logic          clk,
  input logic          rst,
  mux_n_pipe_if.slave  bus
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("mux_n_pipe: STAGES must be 1..3");
  end
  if (NUM_IN < 2) begin : g_bad_num_in
    $error("mux_n_pipe: NUM_IN must be at least 2");
  end
  if ((2 ** SEL_W) < NUM_IN) begin : g_bad_sel_w
    $error("mux_n_pipe: SEL_W too narrow for NUM_IN");
  end

  logic [WIDTH-1:0]  cap_data;
  logic              cap_err;
  logic              sel_ok;

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] err_q;

  // Bubbles carry zero data so the output is deterministic when not valid.
  always_comb begin
    cap_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_ok = 1'b1;
        if (bus.in_valid) begin
          cap_data = bus.din[k*WIDTH +: WIDTH];
        end
      end
    end
    cap_err = bus.in_valid & ~sel_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else if (bus.flush) begin
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
      err_q   <= '0;
    end else if (!bus.stall) begin
      data_q[0]  <= cap_data;
      valid_q[0] <= bus.in_valid;
      err_q[0]   <= cap_err;
      for (int s = 1; s < STAGES; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= err_q[s-1];
      end
    end
  end

  assign bus.out       = data_q[STAGES-1];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sel_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe across four parameter sets sharing clk and rst.
module tb_mux_n_pipe;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) if0 ();
  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) if1 ();
  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) if2 ();
  mux_n_pipe_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) if3 ();

  mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .STAGES(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_n_pipe #(.WIDTH(5), .NUM_IN(3), .SEL_W(2), .STAGES(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .STAGES(3)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  mux_n_pipe #(.WIDTH(5), .NUM_IN(4), .SEL_W(2), .STAGES(2)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    {if0.stall, if0.flush, if0.in_valid, if0.sel} = '0;
    {if1.stall, if1.flush, if1.in_valid, if1.sel} = '0;
    {if2.stall, if2.flush, if2.in_valid, if2.sel} = '0;
    {if3.stall, if3.flush, if3.in_valid, if3.sel} = '0;
    if0.din = {5'd31, 5'd17, 5'd9, 5'd3};
    if1.din = {5'd17, 5'd9, 5'd3};
    if2.din = {5'd31, 5'd17, 5'd9, 5'd3};
    if3.din = {5'd31, 5'd17, 5'd9, 5'd3};

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_out",   32'(if0.out),       0);
    chk("rst_valid", 32'(if0.out_valid), 0);
    chk("rst_err",   32'(if0.sel_err),   0);
    if0.sel = 2'd2; if0.in_valid = 1'b1;
    tick();
    chk("rst_hold_out",   32'(if0.out),       0);
    chk("rst_hold_valid", 32'(if0.out_valid), 0);
    rst = 1'b0;

    // Basic select, STAGES=1
    tick();
    chk("sel2_out",   32'(if0.out),       17);
    chk("sel2_valid", 32'(if0.out_valid), 1);
    chk("sel2_err",   32'(if0.sel_err),   0);
    if0.sel = 2'd3;
    tick();
    chk("sel3_full_out", 32'(if0.out),     31);
    chk("sel3_full_err", 32'(if0.sel_err), 0);
    if0.in_valid = 1'b0;
    tick();
    chk("bubble_valid", 32'(if0.out_valid), 0);
    chk("bubble_out",   32'(if0.out),       0);

    // Illegal select, NUM_IN=3
    if1.sel = 2'd3; if1.in_valid = 1'b1;
    tick();
    chk("ill_out",   32'(if1.out),       0);
    chk("ill_err",   32'(if1.sel_err),   1);
    chk("ill_valid", 32'(if1.out_valid), 1);
    if1.sel = 2'd1;
    tick();
    chk("ill_rec_out", 32'(if1.out),     9);
    chk("ill_rec_err", 32'(if1.sel_err), 0);
    if1.sel = 2'd3; if1.in_valid = 1'b0;
    tick();
    chk("ill_inv_err",   32'(if1.sel_err),   0);
    chk("ill_inv_valid", 32'(if1.out_valid), 0);

    // Latency and throughput, STAGES=3
    if2.sel = 2'd0; if2.in_valid = 1'b1;
    tick();
    chk("lat_e1_valid", 32'(if2.out_valid), 0);
    if2.sel = 2'd1;
    tick();
    chk("lat_e2_valid", 32'(if2.out_valid), 0);
    if2.sel = 2'd2;
    tick();
    chk("lat_e3_out",   32'(if2.out),       3);
    chk("lat_e3_valid", 32'(if2.out_valid), 1);
    if2.sel = 2'd3;
    tick();
    chk("lat_e4_out", 32'(if2.out), 9);
    if2.in_valid = 1'b0;
    tick();
    chk("lat_e5_out", 32'(if2.out), 17);
    tick();
    chk("lat_e6_out", 32'(if2.out), 31);
    tick();
    chk("lat_e7_valid", 32'(if2.out_valid), 0);

    // Stall hold, STAGES=2
    if3.sel = 2'd0; if3.in_valid = 1'b1;
    tick();
    chk("stl_e1_valid", 32'(if3.out_valid), 0);
    if3.sel = 2'd1;
    tick();
    chk("stl_e2_out", 32'(if3.out), 3);
    if3.sel = 2'd2; if3.stall = 1'b1;
    tick();
    chk("stl_h1_out",   32'(if3.out),       3);
    chk("stl_h1_valid", 32'(if3.out_valid), 1);
    tick();
    chk("stl_h2_out", 32'(if3.out), 3);
    if3.stall = 1'b0;
    tick();
    chk("stl_r1_out", 32'(if3.out), 9);
    if3.in_valid = 1'b0;
    tick();
    chk("stl_r2_out",   32'(if3.out),       17);
    chk("stl_r2_valid", 32'(if3.out_valid), 1);
    tick();
    chk("stl_r3_valid", 32'(if3.out_valid), 0);

    // Flush beats stall, STAGES=2
    if3.sel = 2'd0; if3.in_valid = 1'b1;
    tick();
    if3.sel = 2'd1;
    tick();
    chk("fl_pre_out", 32'(if3.out), 3);
    if3.sel = 2'd3; if3.flush = 1'b1; if3.stall = 1'b1;
    tick();
    chk("fl_valid", 32'(if3.out_valid), 0);
    chk("fl_out",   32'(if3.out),       0);
    chk("fl_err",   32'(if3.sel_err),   0);
    if3.flush = 1'b0; if3.stall = 1'b0; if3.in_valid = 1'b0;
    tick();
    chk("fl_post1_valid", 32'(if3.out_valid), 0);
    tick();
    chk("fl_post2_valid", 32'(if3.out_valid), 0);
    chk("fl_post2_out",   32'(if3.out),       0);

    // Asynchronous reset during stall, STAGES=3
    if2.sel = 2'd0; if2.in_valid = 1'b1;
    tick();
    if2.sel = 2'd1;
    tick();
    if2.sel = 2'd2;
    tick();
    chk("ar_full_out", 32'(if2.out), 3);
    if2.stall = 1'b1;
    tick();
    chk("ar_stall_out", 32'(if2.out), 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_clr_out",   32'(if2.out),       0);
    chk("ar_clr_valid", 32'(if2.out_valid), 0);
    #1 rst = 1'b0;
    if2.stall = 1'b0; if2.sel = 2'd1; if2.in_valid = 1'b1;
    tick();
    chk("ar_e1_valid", 32'(if2.out_valid), 0);
    if2.in_valid = 1'b0;
    tick();
    chk("ar_e2_valid", 32'(if2.out_valid), 0);
    tick();
    chk("ar_e3_out",   32'(if2.out),       9);
    chk("ar_e3_valid", 32'(if2.out_valid), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
